// File: rtl/mem_port_arbiter_if.sv
// Bundle between the IF stage, MEM-stage control and the shared memory port.
// The arbiter serves the slave side; requesters and memory sit on master.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          if_stall;

    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_err;
    logic          d_stall;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, MemRead, MemWrite, d_addr, d_wdata,
        input  mem_ack, mem_rdata,
        output if_rdata, if_done, if_stall,
        output d_rdata, d_done, d_err, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, MemRead, MemWrite, d_addr, d_wdata,
        output mem_ack, mem_rdata,
        input  if_rdata, if_done, if_stall,
        input  d_rdata, d_done, d_err, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store.
// Data has priority; a starve counter and an ack timeout bound every wait.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    logic          gnt_d;
    logic [SW-1:0] starve;
    logic [TW-1:0] tmo;

    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          if_done_q;
    logic [DW-1:0] if_rdata_q;
    logic          d_done_q;
    logic          d_err_q;
    logic [DW-1:0] d_rdata_q;

    logic d_req;
    logic d_win;
    logic f_win;
    logic d_bad;
    logic expire;

    assign d_req  = bus.MemRead | bus.MemWrite;
    assign d_win  = d_req & ((starve < SW'(STARVE_MAX)) | ~bus.if_req);
    assign f_win  = ~d_win & bus.if_req;
    assign d_bad  = (bus.MemRead & bus.MemWrite) | (bus.d_addr[1:0] != 2'b00);
    assign expire = (tmo == TW'(TIMEOUT - 1));

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_err     = d_err_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_stall  = bus.if_req & ~if_done_q;
    assign bus.d_stall   = d_req & ~d_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt_d       <= 1'b0;
            starve      <= '0;
            tmo         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_done_q    <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            d_err_q   <= 1'b0;
            if (!bus.if_req) starve <= '0;
            unique case (state)
                IDLE: begin
                    tmo <= '0;
                    if (d_win) begin
                        gnt_d  <= 1'b1;
                        starve <= bus.if_req ? starve + 1'b1 : '0;
                        if (d_bad) begin
                            // rejected accesses never touch memory
                            d_done_q  <= 1'b1;
                            d_err_q   <= 1'b1;
                            d_rdata_q <= '0;
                            state     <= RESP;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.MemWrite;
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                            state       <= WAIT;
                        end
                    end else if (f_win) begin
                        gnt_d       <= 1'b0;
                        starve      <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    tmo <= tmo + 1'b1;
                    if (bus.mem_ack || expire) begin
                        mem_req_q <= 1'b0;
                        state     <= RESP;
                        if (gnt_d) begin
                            d_done_q  <= 1'b1;
                            d_err_q   <= ~bus.mem_ack;
                            d_rdata_q <= (bus.mem_ack && !mem_we_q) ?
                                         bus.mem_rdata : '0;
                        end else begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
                        end
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction timeline model.
// Requesters and memory are driven from the model's own schedule.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT(TO), .STARVE_MAX(SM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // model state: one access in flight, described by cycle numbers
    int          cyc;
    int          idle_at;
    int          wait_lo, wait_hi, ack_cyc, done_cyc;
    bit          done_d;
    bit          e_err;
    logic [31:0] e_rd, ack_data;
    logic [31:0] hold_if, hold_d;
    int          starve;
    bit          e_mwe;
    logic [31:0] e_maddr, e_mwdata;
    int          nfd;

    bit          f_act, f_fin;
    logic [31:0] f_addr;
    bit          d_act, d_fin, d_rd, d_wr;
    logic [31:0] d_addr, d_wdata;
    bit          allow_f, allow_d, hold_mode;

    logic [31:0] dmem [logic [31:0]];

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'h8C22_0004;
    endfunction

    function automatic logic [31:0] dread(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic int pick();
        int s;
        s = int'($urandom % 24);
        if (s == 0) return 20;
        if (s == 1) return TO - 1;
        if (s == 2) return TO;
        return int'($urandom % 4);
    endfunction

    // k = ack delay in WAIT cycles; k >= TO means memory never answers
    task automatic sched(input logic [31:0] rval, input bit store);
        int k;
        k       = pick();
        wait_lo = cyc + 1;
        if (k < TO) begin
            ack_cyc  = cyc + 1 + k;
            done_cyc = cyc + 2 + k;
            e_err    = 1'b0;
            ack_data = rval;
            e_rd     = store ? 32'h0 : rval;
        end else begin
            ack_cyc  = -10;
            done_cyc = cyc + 1 + TO;
            e_err    = 1'b1;
            e_rd     = 32'h0;
        end
        wait_hi = done_cyc - 1;
        idle_at = done_cyc + 1;
    endtask

    task automatic model_reset();
        f_act = 0; f_fin = 0; d_act = 0; d_fin = 0;
        d_rd = 0; d_wr = 0;
        starve = 0; hold_if = 0; hold_d = 0;
        wait_lo = -10; wait_hi = -10; ack_cyc = -10; done_cyc = -10;
        done_d = 0; e_err = 0; e_rd = 0;
        idle_at = cyc + 1;
    endtask

    task automatic step();
        int  kind;
        bit  xf, xd, inw;
        @(posedge clk);
        #1;
        cyc++;
        if (f_fin || !f_act) begin
            f_fin  = 0;
            f_act  = allow_f && (hold_mode || ($urandom % 4 != 0));
            f_addr = $urandom & 32'h0000_03FC;
        end
        if (d_fin || !d_act) begin
            d_fin   = 0;
            d_act   = allow_d && (hold_mode || ($urandom % 3 == 0));
            kind    = hold_mode ? 0 : int'($urandom % 10);
            d_rd    = d_act && (kind < 5 || kind >= 8);
            d_wr    = d_act && ((kind >= 5 && kind < 8) || kind == 9);
            d_addr  = 32'h0000_1000 | ($urandom & 32'h0000_03FC);
            if (kind == 8) d_addr = d_addr | 32'($urandom_range(1, 3));
            d_wdata = $urandom;
        end
        bus.if_req   = f_act;
        bus.if_addr  = f_addr;
        bus.MemRead  = d_rd;
        bus.MemWrite = d_wr;
        bus.d_addr   = d_addr;
        bus.d_wdata  = d_wdata;
        inw = (cyc >= wait_lo) && (cyc <= wait_hi);
        if (cyc == ack_cyc) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = ack_data;
        end else begin
            // stray acks outside WAIT must have no effect
            bus.mem_ack   = !inw && ($urandom % 6 == 0);
            bus.mem_rdata = $urandom;
        end

        @(negedge clk);
        xf = (cyc == done_cyc) && !done_d;
        xd = (cyc == done_cyc) && done_d;
        if (xf) hold_if = e_rd;
        if (xd) hold_d = e_rd;
        if (bus.if_done) nfd++;
        chk("if_done", 32'(bus.if_done), 32'(xf));
        chk("d_done", 32'(bus.d_done), 32'(xd));
        chk("if_rdata", bus.if_rdata, hold_if);
        chk("d_rdata", bus.d_rdata, hold_d);
        if (xd) chk("d_err", 32'(bus.d_err), 32'(e_err));
        chk("if_stall", 32'(bus.if_stall), 32'(f_act && !xf));
        chk("d_stall", 32'(bus.d_stall), 32'(d_act && !xd));
        chk("mem_req", 32'(bus.mem_req), 32'(inw));
        if (inw) begin
            chk("mem_addr", bus.mem_addr, e_maddr);
            chk("mem_we", 32'(bus.mem_we), 32'(e_mwe));
            if (e_mwe) chk("mem_wdata", bus.mem_wdata, e_mwdata);
        end
        if (xf) f_fin = 1;
        if (xd) d_fin = 1;

        // arbitration decision taken at the coming edge
        if (!f_act) starve = 0;
        if (cyc >= idle_at) begin
            if (d_act && (starve < SM || !f_act)) begin
                starve = f_act ? starve + 1 : 0;
                done_d = 1;
                if ((d_rd && d_wr) || d_addr[1:0] != 2'b00) begin
                    done_cyc = cyc + 1;
                    idle_at  = cyc + 2;
                    wait_lo  = -10; wait_hi = -10; ack_cyc = -10;
                    e_err    = 1; e_rd = 0;
                end else begin
                    e_mwe    = d_wr;
                    e_maddr  = d_addr;
                    e_mwdata = d_wdata;
                    sched(d_wr ? $urandom : dread(d_addr), d_wr);
                    if (d_wr && !e_err) dmem[d_addr] = d_wdata;
                end
            end else if (f_act) begin
                starve  = 0;
                done_d  = 0;
                e_mwe   = 0;
                e_maddr = f_addr;
                sched(rom(f_addr), 1'b0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.MemRead = 0; bus.MemWrite = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
        cyc = 0; nfd = 0;
        allow_f = 0; allow_d = 0; hold_mode = 0;
        model_reset();
        #3;
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_done", 32'(bus.if_done), 0);
        chk("rst_d_done", 32'(bus.d_done), 0);
        chk("rst_d_err", 32'(bus.d_err), 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // both requesters always busy: exercises the starvation guard
        allow_f = 1; allow_d = 1; hold_mode = 1;
        repeat (120) step();
        hold_mode = 0;
        repeat (1500) step();

        allow_f = 0; allow_d = 0;
        for (int i = 0; i < 200 && (f_act || d_act || cyc < idle_at); i++)
            step();
        chk("drain", 32'(f_act || d_act || cyc < idle_at), 0);

        // load left hanging in WAIT, then reset between clock edges
        @(posedge clk);
        #1;
        bus.mem_ack = 0;
        bus.if_req = 0;
        bus.MemWrite = 0;
        bus.MemRead = 1;
        bus.d_addr = 32'h0000_1200;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_mem_req", 32'(bus.mem_req), 1);
        #3 rst = 1'b1;
        #1;
        chk("async_mem_req", 32'(bus.mem_req), 0);
        chk("async_d_done", 32'(bus.d_done), 0);
        chk("async_if_done", 32'(bus.if_done), 0);
        chk("async_d_rdata", bus.d_rdata, 0);
        chk("async_if_rdata", bus.if_rdata, 0);
        bus.MemRead = 0;
        @(posedge clk);
        #1;
        chk("held_mem_req", 32'(bus.mem_req), 0);
        rst = 1'b0;

        model_reset();
        allow_f = 1;
        nfd = 0;
        repeat (40) step();
        chk("fetch_after_rst", 32'(nfd > 0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
